// File: rtl/bios_loader.sv
// bios_loader: byte-command loader between the host UART AXI-Stream pair
// and the core's RAM port. Decodes address/burst/byte-write/read commands,
// pulses the core reset, and finally releases the core by going inert.

module bios_loader #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RST_CYCLES   = 16,
    parameter int ACK_EN       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    output logic                      o_rst,
    output logic                      o_booted,
    output logic                      o_read_req,
    output logic [ADDR_WIDTH-1:0]     o_read_addr,
    input  logic [DATA_WIDTH-1:0]     i_read_data,
    output logic                      o_write_enable,
    output logic [DATA_WIDTH/8-1:0]   o_byte_enable,
    output logic [ADDR_WIDTH-1:0]     o_write_addr,
    output logic [DATA_WIDTH-1:0]     o_write_data,
    input  logic [7:0]                i_data,
    input  logic                      i_valid,
    output logic                      o_in_ready,
    output logic [7:0]                o_data,
    output logic                      o_valid,
    input  logic                      i_out_ready
);

    localparam int BPW        = DATA_WIDTH / 8;
    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int ARG_W      = ADDR_BYTES * 8;
    localparam int LANE_BITS  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CNT_W      = 16;
    localparam int RST_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BPW - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(BPW);

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_BOOT     = 8'h01;
    localparam logic [7:0] OP_RST      = 8'h02;
    localparam logic [7:0] OP_SET_ADDR = 8'h03;
    localparam logic [7:0] OP_WR_BURST = 8'h04;
    localparam logic [7:0] OP_RD_BURST = 8'h05;
    localparam logic [7:0] OP_WR_BYTE  = 8'h06;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARG_ADDR,
        S_ARG_CNT,
        S_WR_DATA,
        S_WR_COMMIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_SEND,
        S_RST_PULSE,
        S_ACK,
        S_BOOTED
    } state_t;

    // Where a command lands once it is complete: the ack byte, or straight back to idle.
    localparam state_t DONE_STATE = (ACK_EN != 0) ? S_ACK : S_IDLE;

    state_t                 r_state,     w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr,      w_addr_nxt;
    logic [ARG_W-1:0]       r_arg,       w_arg_nxt;
    logic [DATA_WIDTH-1:0]  r_buf,       w_buf_nxt;
    logic [7:0]             r_cmd,       w_cmd_nxt;
    logic [CNT_W-1:0]       r_cnt,       w_cnt_nxt;
    logic [8:0]             r_words,     w_words_nxt;
    logic [2:0]             r_wait,      w_wait_nxt;
    logic [RST_W-1:0]       r_rst_cnt,   w_rst_cnt_nxt;
    logic                   r_ack_err,   w_ack_err_nxt;
    logic                   r_boot_pend, w_boot_pend_nxt;

    logic [ADDR_WIDTH-1:0]  w_aligned;
    logic [LANE_BITS-1:0]   w_lane;

    assign w_aligned = r_addr & ~ALIGN_MASK;
    assign w_lane    = (BPW > 1) ? r_addr[LANE_BITS-1:0] : '0;

    // State and datapath registers; everything freezes while clk_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_arg       <= '0;
            r_buf       <= '0;
            r_cmd       <= '0;
            r_cnt       <= '0;
            r_words     <= '0;
            r_wait      <= '0;
            r_rst_cnt   <= '0;
            r_ack_err   <= 1'b0;
            r_boot_pend <= 1'b0;
        end else if (clk_en) begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_arg       <= w_arg_nxt;
            r_buf       <= w_buf_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cnt       <= w_cnt_nxt;
            r_words     <= w_words_nxt;
            r_wait      <= w_wait_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_ack_err   <= w_ack_err_nxt;
            r_boot_pend <= w_boot_pend_nxt;
        end
    end

    // Command decoder: next-state/datapath values and Moore-style outputs per state.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_arg_nxt       = r_arg;
        w_buf_nxt       = r_buf;
        w_cmd_nxt       = r_cmd;
        w_cnt_nxt       = r_cnt;
        w_words_nxt     = r_words;
        w_wait_nxt      = r_wait;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_ack_err_nxt   = r_ack_err;
        w_boot_pend_nxt = r_boot_pend;

        o_in_ready      = 1'b0;
        o_valid         = 1'b0;
        o_data          = '0;
        o_read_req      = 1'b0;
        o_read_addr     = '0;
        o_write_enable  = 1'b0;
        o_byte_enable   = '0;
        o_write_addr    = '0;
        o_write_data    = '0;
        o_rst           = 1'b0;
        o_booted        = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_in_ready = clk_en;
                if (i_valid && clk_en) begin
                    w_cmd_nxt     = i_data;
                    w_cnt_nxt     = '0;
                    w_ack_err_nxt = 1'b0;
                    case (i_data)
                        OP_NOP:      w_state_nxt = DONE_STATE;
                        OP_BOOT: begin
                            if (ACK_EN != 0) begin
                                w_boot_pend_nxt = 1'b1;
                                w_state_nxt     = S_ACK;
                            end else begin
                                w_state_nxt     = S_BOOTED;
                            end
                        end
                        OP_RST: begin
                            w_rst_cnt_nxt = '0;
                            w_state_nxt   = S_RST_PULSE;
                        end
                        OP_SET_ADDR: w_state_nxt = S_ARG_ADDR;
                        OP_WR_BURST: w_state_nxt = S_ARG_CNT;
                        OP_RD_BURST: w_state_nxt = S_ARG_CNT;
                        OP_WR_BYTE:  w_state_nxt = S_WR_DATA;
                        default: begin
                            if (ACK_EN != 0) begin
                                w_ack_err_nxt = 1'b1;
                                w_state_nxt   = S_ACK;
                            end
                        end
                    endcase
                end
            end

            S_ARG_ADDR: begin
                o_in_ready = clk_en;
                if (i_valid && clk_en) begin
                    w_arg_nxt = (r_arg >> 8) | (ARG_W'(i_data) << (ARG_W - 8));
                    if (r_cnt == CNT_W'(ADDR_BYTES - 1)) begin
                        w_addr_nxt  = w_arg_nxt[ADDR_WIDTH-1:0];
                        w_cnt_nxt   = '0;
                        w_state_nxt = DONE_STATE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            S_ARG_CNT: begin
                o_in_ready = clk_en;
                if (i_valid && clk_en) begin
                    w_words_nxt = (i_data == 8'h00) ? 9'd256 : {1'b0, i_data};
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_cmd == OP_RD_BURST) ? S_RD_REQ : S_WR_DATA;
                end
            end

            S_WR_DATA: begin
                o_in_ready = clk_en;
                if (i_valid && clk_en) begin
                    if (r_cmd == OP_WR_BYTE) begin
                        w_buf_nxt   = DATA_WIDTH'(i_data);
                        w_state_nxt = S_WR_COMMIT;
                    end else begin
                        w_buf_nxt = (r_buf >> 8) | (DATA_WIDTH'(i_data) << (DATA_WIDTH - 8));
                        if (r_cnt == CNT_W'(BPW - 1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_WR_COMMIT;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            S_WR_COMMIT: begin
                o_write_enable = 1'b1;
                o_write_addr   = w_aligned;
                if (r_cmd == OP_WR_BYTE) begin
                    o_byte_enable = BPW'(1) << w_lane;
                    o_write_data  = DATA_WIDTH'(r_buf[7:0]) << {w_lane, 3'b000};
                    w_addr_nxt    = r_addr + ADDR_WIDTH'(1);
                    w_state_nxt   = DONE_STATE;
                end else begin
                    o_byte_enable = '1;
                    o_write_data  = r_buf;
                    w_addr_nxt    = r_addr + WORD_STEP;
                    w_words_nxt   = r_words - 9'd1;
                    w_state_nxt   = (r_words == 9'd1) ? DONE_STATE : S_WR_DATA;
                end
            end

            S_RD_REQ: begin
                o_read_req  = 1'b1;
                o_read_addr = w_aligned;
                w_wait_nxt  = '0;
                w_state_nxt = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                if (r_wait == 3'(READ_LATENCY - 1)) begin
                    w_buf_nxt   = i_read_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RD_SEND;
                end else begin
                    w_wait_nxt = r_wait + 3'd1;
                end
            end

            S_RD_SEND: begin
                o_valid = 1'b1;
                o_data  = r_buf[7:0];
                if (i_out_ready) begin
                    w_buf_nxt = r_buf >> 8;
                    if (r_cnt == CNT_W'(BPW - 1)) begin
                        w_cnt_nxt   = '0;
                        w_addr_nxt  = r_addr + WORD_STEP;
                        w_words_nxt = r_words - 9'd1;
                        w_state_nxt = (r_words == 9'd1) ? DONE_STATE : S_RD_REQ;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            S_RST_PULSE: begin
                o_rst = 1'b1;
                if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = DONE_STATE;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
                end
            end

            S_ACK: begin
                o_valid = 1'b1;
                o_data  = r_ack_err ? 8'hEE : 8'hA5;
                if (i_out_ready) begin
                    w_state_nxt     = r_boot_pend ? S_BOOTED : S_IDLE;
                    w_boot_pend_nxt = 1'b0;
                end
            end

            S_BOOTED: begin
                o_booted = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: scoreboard bench for bios_loader. Command tasks compute
// the expected stream bytes, RAM writes and RAM reads from a simple address /
// memory model and queue them; negedge monitors pop and compare.

module tb_bios_loader;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int RL   = 2;
    localparam int RSTC = 16;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          o_rst, o_booted, o_read_req, o_write_enable;
    logic [AW-1:0] o_read_addr, o_write_addr;
    logic [DW-1:0] i_read_data = '0;
    logic [3:0]    o_byte_enable;
    logic [DW-1:0] o_write_data;
    logic [7:0]    i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_in_ready;
    logic [7:0]    o_data;
    logic          o_valid;
    logic          i_out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  expOut[$];
    wr_t         expWr[$];
    logic [31:0] expRd[$];
    int          rstExp = 0;
    int          rstSeen = 0;

    logic [31:0] modelAddr = '0;
    logic [31:0] modelMem[logic [31:0]];
    logic [31:0] ramArr[logic [31:0]];

    int  outReadyMode = 0;
    bit  randEn = 1'b0;

    bios_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
        .RST_CYCLES(RSTC), .ACK_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .o_rst(o_rst), .o_booted(o_booted),
        .o_read_req(o_read_req), .o_read_addr(o_read_addr), .i_read_data(i_read_data),
        .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
        .o_write_addr(o_write_addr), .o_write_data(o_write_data),
        .i_data(i_data), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] ramDefault(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ramRead(input logic [31:0] a);
        if (ramArr.exists(a)) return ramArr[a];
        return ramDefault(a);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (modelMem.exists(a)) return modelMem[a];
        return ramDefault(a);
    endfunction

    // Background randomisation of clk_en and downstream ready.
    always @(posedge clk) begin
        #1;
        clk_en = randEn ? ($urandom_range(0, 4) != 0) : 1'b1;
        case (outReadyMode)
            0:       i_out_ready = 1'b1;
            1:       i_out_ready = ~i_out_ready;
            default: i_out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // RAM model with a READ_LATENCY pipeline; junk is driven when no read is due.
    logic        pV[RL+1];
    logic [31:0] pA[RL+1];
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= RL; k++) begin pV[k] = 1'b0; pA[k] = '0; end
            i_read_data = 32'hDEAD_BEEF;
        end else if (clk_en) begin
            if (o_write_enable) begin
                logic [31:0] w;
                w = ramRead(o_write_addr);
                for (int b = 0; b < 4; b++)
                    if (o_byte_enable[b]) w[8*b +: 8] = o_write_data[8*b +: 8];
                ramArr[o_write_addr] = w;
            end
            for (int k = RL; k > 0; k--) begin pV[k] = pV[k-1]; pA[k] = pA[k-1]; end
            pV[0] = o_read_req;
            pA[0] = o_read_addr;
            i_read_data = pV[RL] ? ramRead(pA[RL]) : (32'hDEAD_BEEF ^ $urandom);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    bit          stallPending = 1'b0;
    logic [7:0]  stallData;
    bit          prevWe = 1'b0, prevRq = 1'b0;
    int          rstCnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stallPending = 1'b0; prevWe = 1'b0; prevRq = 1'b0; rstCnt = 0;
        end else begin
            if (stallPending)
                checkOutput("stall_hold", {o_valid, o_data}, {1'b1, stallData});
            stallPending = o_valid && !(i_out_ready && clk_en);
            stallData    = o_data;

            if (o_valid && i_out_ready && clk_en) begin
                if (expOut.size() == 0) checkOutput("unexpected_out_byte", {1'b1, o_data}, 9'h0);
                else checkOutput("out_byte", o_data, expOut.pop_front());
            end

            if (o_write_enable || o_read_req)
                checkOutput("strobe_exclusive", {o_write_enable, o_read_req} == 2'b11, 0);
            if (prevWe) checkOutput("we_single_cycle", o_write_enable, 0);
            if (prevRq) checkOutput("rq_single_cycle", o_read_req, 0);
            prevWe = o_write_enable && clk_en;
            prevRq = o_read_req && clk_en;

            if (o_write_enable && clk_en) begin
                if (expWr.size() == 0) checkOutput("unexpected_write", {o_write_addr, o_write_data}, 0);
                else begin
                    wr_t e;
                    logic [31:0] m;
                    e = expWr.pop_front();
                    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{e.be[b]}};
                    checkOutput("write_addr", o_write_addr, e.addr);
                    checkOutput("write_be", o_byte_enable, e.be);
                    checkOutput("write_data", o_write_data & m, e.data & m);
                end
            end

            if (o_read_req && clk_en) begin
                if (expRd.size() == 0) checkOutput("unexpected_read", {1'b1, o_read_addr}, 0);
                else checkOutput("read_addr", o_read_addr, expRd.pop_front());
            end

            if (o_rst) begin
                if (clk_en) rstCnt++;
            end else if (rstCnt > 0) begin
                checkOutput("rst_len", rstCnt, RSTC);
                rstSeen++;
                rstCnt = 0;
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int  guard = 0;
        bit  taken = 1'b0;
        i_valid = 1'b1;
        i_data  = b;
        while (!taken && guard < 2000) begin
            @(negedge clk);
            taken = o_in_ready;
            guard++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!taken) checkOutput("in_ready_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input logic [7:0] bq[$]);
        @(posedge clk);
        #1;
        foreach (bq[i]) begin
            sendByte(bq[i]);
            if (randEn && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((expOut.size() != 0 || expWr.size() != 0 || expRd.size() != 0 || rstSeen != rstExp)
               && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            checkOutput("drain_timeout", {expOut.size(), expWr.size()}, 0);
            expOut.delete(); expWr.delete(); expRd.delete(); rstSeen = rstExp;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pushWrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_t e;
        logic [31:0] w;
        e.addr = a; e.be = be; e.data = d;
        expWr.push_back(e);
        w = modelRead(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        modelMem[a] = w;
    endtask

    task automatic cmdSimple(input logic [7:0] op);
        logic [7:0] bq[$];
        bq.push_back(op);
        if (op == 8'h02) rstExp++;
        expOut.push_back((op <= 8'h06) ? 8'hA5 : 8'hEE);
        applyStimulus(bq);
        waitDrain();
    endtask

    task automatic cmdSetAddr(input logic [31:0] a);
        logic [7:0] bq[$];
        bq.push_back(8'h03);
        for (int b = 0; b < 4; b++) bq.push_back(a[8*b +: 8]);
        modelAddr = a;
        expOut.push_back(8'hA5);
        applyStimulus(bq);
        waitDrain();
    endtask

    task automatic cmdWrBurst(input int n, input logic [7:0] payload[$]);
        logic [7:0] bq[$];
        int words;
        words = (n == 0) ? 256 : n;
        bq.push_back(8'h04);
        bq.push_back(8'(n));
        for (int w = 0; w < words; w++) begin
            logic [31:0] word;
            for (int b = 0; b < 4; b++) begin
                word[8*b +: 8] = payload[w*4 + b];
                bq.push_back(payload[w*4 + b]);
            end
            pushWrite(modelAddr & ~32'h3, 4'hF, word);
            modelAddr = modelAddr + 32'd4;
        end
        expOut.push_back(8'hA5);
        applyStimulus(bq);
        waitDrain();
    endtask

    task automatic cmdRdBurst(input int n);
        logic [7:0] bq[$];
        int words;
        words = (n == 0) ? 256 : n;
        bq.push_back(8'h05);
        bq.push_back(8'(n));
        for (int w = 0; w < words; w++) begin
            logic [31:0] word;
            expRd.push_back(modelAddr & ~32'h3);
            word = modelRead(modelAddr & ~32'h3);
            for (int b = 0; b < 4; b++) expOut.push_back(word[8*b +: 8]);
            modelAddr = modelAddr + 32'd4;
        end
        expOut.push_back(8'hA5);
        applyStimulus(bq);
        waitDrain();
    endtask

    task automatic cmdWrByte(input logic [7:0] v);
        logic [7:0] bq[$];
        int lane;
        lane = int'(modelAddr % 4);
        bq.push_back(8'h06);
        bq.push_back(v);
        pushWrite(modelAddr & ~32'h3, 4'(1 << lane), 32'(v) << (8 * lane));
        modelAddr = modelAddr + 32'd1;
        expOut.push_back(8'hA5);
        applyStimulus(bq);
        waitDrain();
    endtask

    function automatic void randPayload(input int words, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < words * 4; i++) q.push_back(8'($urandom));
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] pl[$];
        bit sawReady;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_ctrl", {o_rst, o_booted, o_read_req, o_write_enable, o_valid, o_in_ready}, 6'b000001);
        checkOutput("reset_addrs", {o_read_addr, o_write_addr}, 0);
        checkOutput("reset_wdata", {o_write_data, o_data, o_byte_enable}, 0);
        rst_n = 1'b1;

        // Directed sequence
        cmdSetAddr(32'h0000_0010);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        cmdWrBurst(2, pl);
        cmdSetAddr(32'h0000_0010);
        outReadyMode = 1;
        cmdRdBurst(2);
        outReadyMode = 0;
        cmdSetAddr(32'h0000_0013);
        cmdWrByte(8'hAB);
        cmdRdBurst(1);
        cmdSetAddr(32'hFFFF_FFFC);
        randPayload(2, pl);
        cmdWrBurst(2, pl);
        cmdSetAddr(32'hFFFF_FFFC);
        cmdRdBurst(2);
        cmdSimple(8'h7F);
        cmdWrByte(8'h5D);
        cmdSimple(8'h00);
        cmdSimple(8'h02);

        // Randomised phase with clk_en and ready jitter
        randEn = 1'b1;
        outReadyMode = 2;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: cmdSimple(8'h00);
                1: cmdSetAddr(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : 32'($urandom));
                2: begin
                    int n;
                    n = $urandom_range(1, 4);
                    randPayload(n, pl);
                    cmdWrBurst(n, pl);
                end
                3: cmdRdBurst($urandom_range(1, 4));
                4: cmdWrByte(8'($urandom));
                5: cmdSimple(8'($urandom_range(7, 255)));
                default: cmdSimple(8'h02);
            endcase
        end
        cmdSetAddr(32'hFFFF_FF00);
        randPayload(256, pl);
        cmdWrBurst(0, pl);
        cmdSetAddr(32'hFFFF_FF00);
        cmdRdBurst(0);

        // Boot: ack first, then the block goes inert
        randEn = 1'b0;
        outReadyMode = 0;
        expOut.push_back(8'hA5);
        pl = '{8'h01};
        applyStimulus(pl);
        waitDrain();
        checkOutput("booted", o_booted, 1);
        checkOutput("in_ready_after_boot", o_in_ready, 0);
        sawReady = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h03;
        repeat (20) begin
            @(negedge clk);
            if (o_in_ready || o_valid || o_write_enable || o_read_req) sawReady = 1'b1;
        end
        i_valid = 1'b0;
        checkOutput("booted_inert", sawReady, 0);

        // Reset out of BOOTED, then abort a burst mid-word
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("booted_cleared", o_booted, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        modelAddr = '0;
        pl = '{8'h04, 8'h02, 8'h11, 8'h22, 8'h33};
        applyStimulus(pl);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ctrl", {o_rst, o_booted, o_read_req, o_write_enable, o_valid}, 0);
        checkOutput("abort_bus", {o_write_addr, o_write_data, o_byte_enable}, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        modelAddr = '0;
        cmdWrByte(8'h5C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bios_loader.md
Name: bios_loader

Overview:
- Parametrised successor of the single-word serial BIOS.
- Decodes an 8-bit AXI-Stream command byte stream from the host UART bridge into RAM accesses, core reset pulses and a boot release.
- Generalised to any word width, with a multi-byte address, auto-incrementing burst write/read, per-byte write, and an optional per-command acknowledge byte.
- Sits between the UART AXI-Stream pair and the core's RAM port; goes inert once boot is issued.

Parameters:
- ADDR_WIDTH, 32: RAM byte-address width; ADDR_BYTES = ceil(ADDR_WIDTH/8).
- DATA_WIDTH, 32: RAM word width; multiple of 8; BPW = DATA_WIDTH/8 lanes.
- READ_LATENCY, 1: cycles from o_read_req to valid i_read_data; range 1..7.
- RST_CYCLES, 16: length of the o_rst pulse in enabled cycles; at least 1.
- ACK_EN, 1: when 1, emit a status byte after every completed command.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  advance enable; when 0, all state, counters and outputs hold and o_in_ready=0
- o_rst  out  1  core reset pulse
- o_booted  out  1  sticky boot flag
- o_read_req  out  1  one-cycle RAM read strobe
- o_read_addr  out  ADDR_WIDTH  word-aligned read address
- i_read_data  in  DATA_WIDTH  RAM read data
- o_write_enable  out  1  one-cycle RAM write strobe
- o_byte_enable  out  BPW  lane mask for the write
- o_write_addr  out  ADDR_WIDTH  word-aligned write address
- o_write_data  out  DATA_WIDTH  write data
- i_data  in  8  AXI-S input byte
- i_valid  in  1  input valid
- o_in_ready  out  1  input ready
- o_data  out  8  AXI-S output byte
- o_valid  out  1  output valid
- i_out_ready  in  1  output ready

Behaviour:
Reset (rst_n=0, asynchronous): state=IDLE; address register=0; all outputs 0, except o_in_ready=1 once clk_en is 1.

Input handshake:
- A byte is consumed when i_valid & o_in_ready at a clk edge with clk_en=1.
- o_in_ready = clk_en & (state is IDLE, ARG_ADDR, ARG_CNT or WR_DATA).

Output handshake:
- o_data and o_valid hold stable until i_out_ready; there are no bubbles inside a byte.

Opcodes (anything else is an error):
- 0x00 NOP: no operation.
- 0x01 BOOT: go to BOOTED.
- 0x02 RST: go to RST_PULSE.
- 0x03 SET_ADDR: ARG_ADDR takes ADDR_BYTES bytes, little-endian, into addr; excess high bits are dropped.
- 0x04 WR_BURST: ARG_CNT takes count N (0 means 256). WR_DATA takes N*BPW bytes LSB-first into a word shift buffer. After each full word, WR_COMMIT runs for one cycle:
  - o_write_enable=1, o_byte_enable=all 1s;
  - o_write_addr = addr with its low log2(BPW) bits cleared;
  - addr += BPW.
- 0x05 RD_BURST: ARG_CNT takes N. Per word:
  - RD_REQ (one cycle): o_read_req=1, o_read_addr = aligned addr.
  - RD_WAIT: READ_LATENCY cycles, then capture i_read_data.
  - RD_SEND: BPW bytes LSB-first on the output stream, then addr += BPW.
- 0x06 WR_BYTE: WR_DATA takes 1 byte. WR_COMMIT then places it in lane addr mod BPW, with o_byte_enable one-hot on that lane, and addr += 1.

Address arithmetic:
- Wraps modulo 2^ADDR_WIDTH with no error.
- A burst crossing the top of the address space continues from 0.

Acknowledge (ACK state, ACK_EN=1):
- Emits 0xA5 after NOP/RST/SET_ADDR/WR_*/RD_BURST complete. For RD_BURST it follows the last data byte.
- An unknown opcode emits 0xEE and returns to IDLE with addr unchanged.
- With ACK_EN=0 there is no ack byte; unknown opcodes are silently dropped.

RST_PULSE:
- o_rst=1 for exactly RST_CYCLES enabled cycles, then ACK or IDLE.
- Input is not accepted during the pulse.

BOOTED:
- o_booted=1 one cycle after the BOOT byte is consumed. With ACK_EN=1, 0xA5 is sent first and then o_booted rises.
- Terminal state: o_in_ready=0, no further RAM or stream activity until rst_n.

Boundary conditions:
- Strobes o_read_req and o_write_enable are always single-cycle and never asserted together.
- clk_en low mid-burst freezes the block, including the RD_WAIT counter. The RAM is assumed to hold i_read_data while clk_en is low.
- rst_n asserted mid-burst aborts immediately: a partial word is discarded and no write is issued.

Test Plan:
- Reset, then SET_ADDR 0x10 0x00 0x00 0x00 -> addr=0x10; ack 0xA5; no RAM strobes.
- WR_BURST N=2, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211 @0x10 and 0x88776655 @0x14, byte_enable=0xF; two ack-free strobes, then 0xA5.
- SET_ADDR 0x10, RD_BURST N=2, RAM returning the above with READ_LATENCY=2; i_out_ready toggling 1/0 -> output 11 22 33 44 55 66 77 88 A5 in order, o_data stable while stalled.
- SET_ADDR 0x13, WR_BYTE 0xAB -> o_write_addr=0x10, o_byte_enable=0b1000, data[31:24]=0xAB; addr becomes 0x14.
- SET_ADDR 0xFFFFFFFC, WR_BURST N=2 -> writes @0xFFFFFFFC then @0x00000000.
- Opcode 0x7F -> 0xEE. RST -> o_rst high exactly 16 cycles. BOOT -> 0xA5, o_booted=1, o_in_ready=0 thereafter. Pull rst_n low mid-WR_BURST -> no write strobe, outputs 0.
